// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT sample buffer controller: one-hot state
// encodings, inspect-select codes and a constant clog2 helper.
package fft_buf_pkg;

  typedef enum logic [3:0] {
    ST_INIT = 4'b1000,
    ST_IDLE = 4'b0100,
    ST_PROC = 4'b0010,
    ST_DONE = 4'b0001
  } state_t;

  // Insp_sel: bit0 picks Re/Im, bit1 picks the high 16-bit window.
  localparam logic [1:0] SEL_RE_LO = 2'b00;
  localparam logic [1:0] SEL_IM_LO = 2'b01;
  localparam logic [1:0] SEL_RE_HI = 2'b10;
  localparam logic [1:0] SEL_IM_HI = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fft_buf_ctrl_if.sv
// Butterfly-engine bus between the buffer controller (slave) and the engine
// (master): start pulse, read/write strobes, butterfly addresses and data.
interface fft_buf_ctrl_if #(
  parameter int N  = 256,
  parameter int DW = 32
);
  import fft_buf_pkg::*;
  localparam int AW = clog2(N);

  logic                 Eng_start;
  logic                 Eng_rd;
  logic                 Eng_wr;
  logic                 Eng_done;
  logic [AW-1:0]        i_top;
  logic [AW-1:0]        i_bot;
  logic signed [DW-1:0] x_top_re, x_top_im, x_bot_re, x_bot_im;
  logic signed [DW-1:0] y_top_re, y_top_im, y_bot_re, y_bot_im;

  modport master (
    input  Eng_start, x_top_re, x_top_im, x_bot_re, x_bot_im,
    output Eng_rd, Eng_wr, Eng_done, i_top, i_bot,
           y_top_re, y_top_im, y_bot_re, y_bot_im
  );

  modport slave (
    output Eng_start, x_top_re, x_top_im, x_bot_re, x_bot_im,
    input  Eng_rd, Eng_wr, Eng_done, i_top, i_bot,
           y_top_re, y_top_im, y_bot_re, y_bot_im
  );

endinterface

// File: rtl/fft_buf_ram.sv
// One DW-wide, N-deep sample bank: two write ports (port B wins on equal
// addresses), two registered read ports returning pre-write data, one peek port.
module fft_buf_ram #(
  parameter int N  = 256,
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 we_a,
  input  logic [AW-1:0]        addr_a,
  input  logic signed [DW-1:0] wd_a,
  input  logic                 we_b,
  input  logic [AW-1:0]        addr_b,
  input  logic signed [DW-1:0] wd_b,
  input  logic                 rd_en,
  input  logic [AW-1:0]        ra_a,
  input  logic [AW-1:0]        ra_b,
  output logic signed [DW-1:0] rd_a_p1,
  output logic signed [DW-1:0] rd_b_p1,
  input  logic [AW-1:0]        pk_addr,
  output logic signed [DW-1:0] pk_data
);

  logic signed [DW-1:0] mem [N];

  always_ff @(posedge Clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
  end

  // ---- read stage p0 -> p1 ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else if (rd_en) begin
      rd_a_p1 <= mem[ra_a];
      rd_b_p1 <= mem[ra_b];
    end
  end

  assign pk_data = mem[pk_addr];

endmodule

// File: rtl/fft_buf_ctrl.sv
// FFT sample buffer controller: LUT preload, engine read/write arbitration,
// and a 4-nibble inspect display. Define FFT_BUF_MAG_EN for |Re|+|Im| display.
module fft_buf_ctrl
  import fft_buf_pkg::*;
#(
  parameter  int N  = 256,
  parameter  int DW = 32,
  localparam int AW = clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  output logic [AW-1:0]        Init_addr,
  input  logic signed [DW-1:0] Init_data,
  fft_buf_ctrl_if.slave        eng,
  input  logic [AW-1:0]        Inspect,
  input  logic [1:0]           Insp_sel,
  output logic [3:0]           Inspect_0,
  output logic [3:0]           Inspect_1,
  output logic [3:0]           Inspect_2,
  output logic [3:0]           Inspect_3,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Done,
  output logic                 ActivateSSD
);

  state_t state;

  function automatic logic [15:0] pick_window(input logic signed [DW-1:0] w, input logic hi);
    logic [31:0] ext;
    ext = '0;
    ext[DW-1:0] = w;
    if (hi && (DW == 32)) return ext[31:16];
    return ext[15:0];
  endfunction

`ifdef FFT_BUF_MAG_EN
  function automatic logic [15:0] sat_mag(input logic signed [DW-1:0] re,
                                          input logic signed [DW-1:0] im);
    logic [DW-1:0] ar, ai;
    logic [DW:0]   s;
    ar = re[DW-1] ? DW'(-re) : DW'(re);
    ai = im[DW-1] ? DW'(-im) : DW'(im);
    s  = {1'b0, ar} + {1'b0, ai};
    if (s > (DW+1)'(16'hFFFF)) return 16'hFFFF;
    return s[15:0];
  endfunction
`endif

  assign Ready       = (state == ST_IDLE);
  assign Busy        = (state == ST_PROC);
  assign Done        = (state == ST_DONE);
  assign ActivateSSD = (state == ST_IDLE) || (state == ST_DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_INIT;
      Init_addr     <= '0;
      eng.Eng_start <= 1'b0;
    end else begin
      eng.Eng_start <= 1'b0;
      case (state)
        ST_INIT: begin
          Init_addr <= AW'(Init_addr + 1'b1);
          if (Init_addr == AW'(N - 1)) state <= ST_IDLE;
        end
        ST_IDLE: if (Start) begin
          state         <= ST_PROC;
          eng.Eng_start <= 1'b1;
        end
        ST_PROC: if (eng.Eng_done) state <= ST_DONE;
        ST_DONE: if (Ack) state <= ST_IDLE;
        default: begin
          state     <= ST_INIT;
          Init_addr <= '0;
        end
      endcase
    end
  end

  // INIT borrows write port A for the preload; engine traffic only lands in PROC.
  logic          in_init, in_proc, we_a, we_b, rd_en;
  logic [AW-1:0] addr_a;
  logic signed [DW-1:0] wd_a_re, wd_a_im, pk_re, pk_im;

  assign in_init = (state == ST_INIT);
  assign in_proc = (state == ST_PROC);
  assign we_a    = !Reset && (in_init || (in_proc && eng.Eng_wr));
  assign we_b    = !Reset && in_proc && eng.Eng_wr;
  assign rd_en   = in_proc && eng.Eng_rd;
  assign addr_a  = in_init ? Init_addr : eng.i_top;
  assign wd_a_re = in_init ? Init_data : eng.y_top_re;
  assign wd_a_im = in_init ? '0        : eng.y_top_im;

  fft_buf_ram #(.N(N), .DW(DW), .AW(AW)) u_re (
    .Clk(Clk), .Reset(Reset),
    .we_a(we_a), .addr_a(addr_a), .wd_a(wd_a_re),
    .we_b(we_b), .addr_b(eng.i_bot), .wd_b(eng.y_bot_re),
    .rd_en(rd_en), .ra_a(eng.i_top), .ra_b(eng.i_bot),
    .rd_a_p1(eng.x_top_re), .rd_b_p1(eng.x_bot_re),
    .pk_addr(Inspect), .pk_data(pk_re)
  );

  fft_buf_ram #(.N(N), .DW(DW), .AW(AW)) u_im (
    .Clk(Clk), .Reset(Reset),
    .we_a(we_a), .addr_a(addr_a), .wd_a(wd_a_im),
    .we_b(we_b), .addr_b(eng.i_bot), .wd_b(eng.y_bot_im),
    .rd_en(rd_en), .ra_a(eng.i_top), .ra_b(eng.i_bot),
    .rd_a_p1(eng.x_top_im), .rd_b_p1(eng.x_bot_im),
    .pk_addr(Inspect), .pk_data(pk_im)
  );

  logic [15:0] win_p0, win_p1;

  always_comb begin
    win_p0 = pick_window(Insp_sel[0] ? pk_im : pk_re, Insp_sel[1]);
`ifdef FFT_BUF_MAG_EN
    if (Insp_sel == SEL_IM_HI) win_p0 = sat_mag(pk_re, pk_im);
`endif
  end

  // ---- inspect stage p0 -> p1 ----
  always_ff @(posedge Clk) begin
    if (Reset)            win_p1 <= '0;
    else if (ActivateSSD) win_p1 <= win_p0;
  end

  assign {Inspect_3, Inspect_2, Inspect_1, Inspect_0} = win_p1;

endmodule

// File: tb/tb_fft_buf_ctrl.sv
// Directed bench for fft_buf_ctrl with N=16, DW=32 and an addr*3 init LUT.
module tb_fft_buf_ctrl;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int AW = 4;

  logic Clk = 1'b0;
  logic Reset, Start, Ack;
  logic [AW-1:0] Init_addr, Inspect;
  logic signed [DW-1:0] Init_data;
  logic [1:0] Insp_sel;
  logic [3:0] Inspect_0, Inspect_1, Inspect_2, Inspect_3;
  logic Ready, Busy, Done, ActivateSSD;
  int checks = 0;
  int errors = 0;

  fft_buf_ctrl_if #(.N(N), .DW(DW)) eng ();

  fft_buf_ctrl #(.N(N), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .Init_addr(Init_addr), .Init_data(Init_data), .eng(eng),
    .Inspect(Inspect), .Insp_sel(Insp_sel),
    .Inspect_0(Inspect_0), .Inspect_1(Inspect_1),
    .Inspect_2(Inspect_2), .Inspect_3(Inspect_3),
    .Ready(Ready), .Busy(Busy), .Done(Done), .ActivateSSD(ActivateSSD)
  );

  assign Init_data = 32'(Init_addr) * 32'd3;

  always #5 Clk = ~Clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] insp();
    return {16'h0, Inspect_3, Inspect_2, Inspect_1, Inspect_0};
  endfunction

  task automatic eng_idle();
    eng.Eng_rd = 0; eng.Eng_wr = 0; eng.Eng_done = 0;
  endtask

  task automatic eng_wr(input logic [AW-1:0] t, input logic [AW-1:0] b,
                        input logic [31:0] tre, input logic [31:0] tim,
                        input logic [31:0] bre, input logic [31:0] bim);
    eng.Eng_wr = 1; eng.i_top = t; eng.i_bot = b;
    eng.y_top_re = tre; eng.y_top_im = tim; eng.y_bot_re = bre; eng.y_bot_im = bim;
  endtask

  task automatic peek(input logic [AW-1:0] a, input logic [1:0] s);
    Inspect = a; Insp_sel = s;
    tick();
  endtask

  initial begin
    Reset = 1; Start = 0; Ack = 0; Inspect = '0; Insp_sel = 2'b00;
    eng_idle(); eng.i_top = '0; eng.i_bot = '0;
    eng.y_top_re = '0; eng.y_top_im = '0; eng.y_bot_re = '0; eng.y_bot_im = '0;
    tick(2);
    chk("rst_ready", 32'(Ready), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ssd", 32'(ActivateSSD), 32'd0);
    chk("rst_init_addr", 32'(Init_addr), 32'd0);
    chk("rst_eng_start", 32'(eng.Eng_start), 32'd0);
    chk("rst_x_top_re", eng.x_top_re, 32'd0);
    chk("rst_inspect", insp(), 32'h0);

    // Preload: 16 INIT cycles after reset release
    Reset = 0;
    tick(15);
    chk("init_ready_early", 32'(Ready), 32'd0);
    chk("init_addr_15", 32'(Init_addr), 32'd15);
    tick();
    chk("init_ready", 32'(Ready), 32'd1);
    chk("init_ssd", 32'(ActivateSSD), 32'd1);

    peek(4'd5, 2'b00); chk("insp_re5", insp(), 32'h000F);
    peek(4'd5, 2'b10); chk("insp_re5_hi", insp(), 32'h0000);
    peek(4'd7, 2'b00); chk("insp_re7", insp(), 32'h0015);
    peek(4'd7, 2'b01); chk("insp_im7", insp(), 32'h0000);
    peek(4'd7, 2'b00);

    // Start held three cycles gives a single Eng_start pulse
    Start = 1;
    tick(); chk("start_pulse", 32'(eng.Eng_start), 32'd1);
    chk("start_busy", 32'(Busy), 32'd1);
    chk("start_ready", 32'(Ready), 32'd0);
    tick(); chk("start_pulse_2", 32'(eng.Eng_start), 32'd0);
    tick(); chk("start_pulse_3", 32'(eng.Eng_start), 32'd0);
    Start = 0;
    peek(4'd5, 2'b00); chk("insp_hold_proc", insp(), 32'h0015);

    eng_wr(4'd2, 4'd3, 32'h1234, 32'h55, 32'h77, 32'hFFFF_FFFF);
    tick(); eng_idle(); eng.Eng_rd = 1;
    tick();
    chk("rd_top_re", eng.x_top_re, 32'h1234);
    chk("rd_top_im", eng.x_top_im, 32'h55);
    chk("rd_bot_re", eng.x_bot_re, 32'h77);
    chk("rd_bot_im", eng.x_bot_im, 32'hFFFF_FFFF);
    eng_idle(); eng.i_top = 4'd0;
    tick(); chk("rd_hold", eng.x_top_re, 32'h1234);

    // Read and write to the same address in one cycle returns old data
    eng_wr(4'd2, 4'd3, 32'h9999, 32'h0, 32'h88, 32'h0); eng.Eng_rd = 1;
    tick(); chk("rdw_old", eng.x_top_re, 32'h1234);
    eng.Eng_wr = 0;
    tick(); chk("rdw_new", eng.x_top_re, 32'h9999);
    chk("rdw_new_bot", eng.x_bot_re, 32'h88);
    eng_idle();

    eng_wr(4'd4, 4'd4, 32'hA, 32'h0, 32'hB, 32'h0);
    tick(); eng_idle(); eng.Eng_rd = 1;
    tick(); chk("collide_top", eng.x_top_re, 32'hB);
    eng_idle();
    eng_wr(4'd7, 4'd8, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0);
    tick();

    // Write alongside Eng_done still commits
    eng_wr(4'd5, 4'd6, 32'h111, 32'h0, 32'h222, 32'h0); eng.Eng_done = 1;
    tick(); eng_idle();
    chk("done_flag", 32'(Done), 32'd1);
    chk("done_busy", 32'(Busy), 32'd0);
    eng_wr(4'd5, 4'd6, 32'hDEAD, 32'h0, 32'hBEEF, 32'h0);
    Start = 1;
    tick(); eng_idle(); Start = 0;
    chk("done_start_ign", 32'(Done), 32'd1);
    chk("done_no_pulse", 32'(eng.Eng_start), 32'd0);
    peek(4'd5, 2'b00); chk("insp_re5_done", insp(), 32'h0111);
    peek(4'd6, 2'b00); chk("insp_re6_done", insp(), 32'h0222);

    Ack = 1;
    tick(); Ack = 0;
    chk("ack_ready", 32'(Ready), 32'd1);
    peek(4'd4, 2'b00); chk("insp_re4_kept", insp(), 32'h000B);
    peek(4'd7, 2'b10); chk("insp_re7_hi", insp(), 32'hFFFF);
`ifdef FFT_BUF_MAG_EN
    peek(4'd7, 2'b11); chk("insp_mag7", insp(), 32'h0008);
`else
    peek(4'd7, 2'b11); chk("insp_im7_hi", insp(), 32'h0000);
`endif
    peek(4'd7, 2'b01); chk("insp_im7_lo", insp(), 32'h0005);

    // Engine strobes outside PROC are ignored
    eng.Eng_rd = 1; eng.i_top = 4'd0; eng_wr(4'd0, 4'd1, 32'h5A5A, 32'h0, 32'h0, 32'h0);
    tick(); eng_idle();
    chk("idle_rd_ign", eng.x_top_re, 32'hB);
    peek(4'd0, 2'b00); chk("idle_wr_ign", insp(), 32'h0000);

    // Reset in the middle of PROC reloads the buffer
    Start = 1; tick(); Start = 0;
    chk("proc_again", 32'(Busy), 32'd1);
    tick(2);
    Reset = 1; eng.Eng_wr = 1; eng.Eng_done = 1;
    tick(); Reset = 0; eng_idle();
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_addr", 32'(Init_addr), 32'd0);
    chk("rst_mid_ready", 32'(Ready), 32'd0);
    tick(16);
    chk("reinit_ready", 32'(Ready), 32'd1);
    peek(4'd4, 2'b00); chk("reinit_re4", insp(), 32'h000C);
    peek(4'd7, 2'b01); chk("reinit_im7", insp(), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_buf_ctrl.md
FFT_BUF_CTRL -- requirements
Module: fft_buf_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, number of complex points (power of two, 8..1024).
REQ-002 SHALL have parameter DW, default 32, signed sample width per Re/Im component (16..32).
REQ-003 SHALL derive localparam AW = clog2(N) for all address ports.
REQ-004 Clk  in  1  single clock; all logic on posedge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Start  in  1  request transform; honoured only in IDLE.
REQ-007 Ack  in  1  release DONE back to IDLE, keeping buffer contents.
REQ-008 Init_addr  out  AW  address to external initial-value LUT.
REQ-009 Init_data  in  DW  LUT real value for Init_addr, combinational.
REQ-010 Eng_start  out  1  one-cycle pulse starting the butterfly engine.
REQ-011 Eng_rd  in  1  engine read strobe; i_top/i_bot valid.
REQ-012 i_top, i_bot  in  AW each  engine butterfly addresses.
REQ-013 x_top_re, x_top_im, x_bot_re, x_bot_im  out  DW each  read data.
REQ-014 Eng_wr  in  1  engine write-back strobe, using i_top/i_bot.
REQ-015 y_top_re, y_top_im, y_bot_re, y_bot_im  in  DW each  write-back data.
REQ-016 Eng_done  in  1  engine finished all stages.
REQ-017 Inspect  in  AW  bin index to display.
REQ-018 Insp_sel  in  2  bit0: 0=Re, 1=Im; bit1: 0=bits[15:0], 1=bits[31:16] (DW=32 only, else bits[15:0]).
REQ-019 Inspect_0..Inspect_3  out  4 each  nibbles of selected 16-bit window, Inspect_0 least significant.
REQ-020 Ready, Busy, Done, ActivateSSD  out  1 each  IDLE, PROC, DONE, IDLE-or-DONE.

Function
REQ-021 SHALL implement one-hot FSM INIT=1000, IDLE=0100, PROC=0010, DONE=0001; illegal encoding SHALL go to INIT next cycle.
REQ-022 INIT: each cycle write Re[Init_addr]<=Init_data, Im[Init_addr]<=0, increment Init_addr; at Init_addr==N-1 write then go IDLE; INIT lasts exactly N cycles.
REQ-023 IDLE: Start=1 -> PROC and Eng_start=1 for exactly that transition cycle; Start in any other state ignored.
REQ-024 PROC: Eng_rd -> x_* = buffer[i_top]/[i_bot] registered, one-cycle latency; x_* hold value otherwise.
REQ-025 PROC: Eng_wr -> write y_top_* to i_top and y_bot_* to i_bot same cycle; i_top==i_bot -> bottom data wins.
REQ-026 Eng_rd and Eng_wr same cycle same address SHALL return pre-write (old) data.
REQ-027 Eng_wr/Eng_rd outside PROC SHALL be ignored, no buffer change.
REQ-028 PROC: Eng_done -> DONE; a write in the same cycle SHALL still commit.
REQ-029 DONE: Ack -> IDLE with buffer intact; no Ack -> stay; Start in DONE ignored.
REQ-030 When ActivateSSD, Inspect_* SHALL update from Inspect/Insp_sel with one-cycle latency; otherwise hold.

Reset
REQ-031 Reset SHALL dominate all inputs, including mid-INIT and mid-PROC.
REQ-032 Reset values: state INIT, Init_addr 0, Eng_start 0, x_* 0, Inspect_* 0; buffer not cleared (reloaded by INIT).
REQ-033 Ready, Busy, Done, ActivateSSD SHALL decode from state, so 0 during and after reset until INIT ends.

Configuration
REQ-034 With FFT_BUF_MAG_EN defined, Insp_sel==2'b11 SHALL display low 16 bits of |Re|+|Im| (DW+1-bit sum, saturating at 16'hFFFF) instead of Im high word.
REQ-035 Without FFT_BUF_MAG_EN, no magnitude logic SHALL exist and Insp_sel==2'b11 SHALL behave per REQ-018.

Structure
REQ-036 Package fft_buf_pkg SHALL hold state encodings, Insp_sel codes and clog2 function.
REQ-037 Sub-module fft_buf_ram SHALL hold one DW-wide N-deep two-write/two-read bank; instantiated twice (Re, Im).

Verification
REQ-038 N=16, LUT Init_data=addr*3: reset, 16 cycles -> Ready=1 cycle 17; Inspect=5, Insp_sel=0 -> Inspect_3..0 = 0,0,0,F.
REQ-039 Start in IDLE -> Eng_start single pulse, Busy=1; Start held 3 cycles -> still one pulse.
REQ-040 PROC: Eng_wr i_top=2,i_bot=3 y_top_re=0x1234,y_bot_im=-1; next Eng_rd same addrs -> x_top_re=0x1234, x_bot_im=0xFFFFFFFF.
REQ-041 i_top=i_bot=4 write 0xA/0xB -> Re[4]=0xB; Eng_done -> Done=1; Ack -> Ready=1, Re[4] still 0xB.
REQ-042 Reset asserted mid-PROC -> next cycle INIT, Init_addr=0, Busy=0; after N cycles Re[4] restored to 12.
REQ-043 FFT_BUF_MAG_EN: Re=-3, Im=5, Insp_sel=3 -> Inspect_* = 0,0,0,8.
